// File: rtl/abc_seq_scheduler.sv
// Round-robin scheduler that shares one a->b->c phase-pulse datapath among NREQ requesters.
// Each grant runs a single a ##1 b ##1 c sequence, followed by GAP forced idle cycles.
module abc_seq_scheduler #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned GAP  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    abort,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    a,
    output logic                    b,
    output logic                    c,
    output logic                    done,
    output logic                    busy
);

    localparam int unsigned IDW      = $clog2(NREQ);
    localparam logic [3:0]  GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        PH_A,
        PH_B,
        PH_C,
        PH_GAP
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_grant_id;
    logic [IDW-1:0]  r_last;
    logic [3:0]      r_gap_cnt;
    logic            r_a, r_b, r_c, r_done, r_busy;

    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;
    logic            w_found;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = IDW'((32'(r_last) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_grant_id <= '0;
            r_last     <= IDW'(NREQ - 1);
            r_gap_cnt  <= '0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_c        <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= PH_A;
                        r_gnt      <= NREQ'(1) << w_win;
                        r_grant_id <= w_win;
                        r_last     <= w_win;
                        r_a        <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                PH_A, PH_B: begin
                    r_a <= 1'b0;
                    if (abort) begin
                        // Aborted sequences take the same exit path as a completed one.
                        r_gnt     <= '0;
                        r_b       <= 1'b0;
                        r_gap_cnt <= GAP_LOAD;
                        r_busy    <= (GAP > 0);
                        r_state   <= (GAP > 0) ? PH_GAP : IDLE;
                    end else if (r_state == PH_A) begin
                        r_state <= PH_B;
                        r_b     <= 1'b1;
                    end else begin
                        r_state <= PH_C;
                        r_b     <= 1'b0;
                        r_c     <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                PH_C: begin
                    r_gnt     <= '0;
                    r_c       <= 1'b0;
                    r_done    <= 1'b0;
                    r_gap_cnt <= GAP_LOAD;
                    r_busy    <= (GAP > 0);
                    r_state   <= (GAP > 0) ? PH_GAP : IDLE;
                end
                PH_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                    r_c     <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign grant_id = r_grant_id;
    assign a        = r_a;
    assign b        = r_b;
    assign c        = r_c;
    assign done     = r_done;
    assign busy     = r_busy;

endmodule
